// File: rtl/seg_frame_capture.sv
// ============================================================================
// Module   : seg_frame_capture
// Purpose  : Samples a 6-digit multiplexed active-low 7-segment bus, decodes
//            each digit and assembles complete frames into a 24-bit word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_frame_capture #(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 8000000
) (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic        sel1,
    input  logic        sel2,
    input  logic        sel3,
    input  logic        sel4,
    input  logic        sel5,
    input  logic        sel6,
    input  logic [7:0]  led,
    input  logic        clr_err,
    output logic [23:0] data,
    output logic        frame_stb,
    output logic        frame_valid,
    output logic        code_err,
    output logic        sel_err
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SETTLE = 2'd1, ST_HOLD = 2'd2} state_t;

    state_t      state, state_next;
    logic [5:0]  sel_raw, sel_m, sel_s, sel_d;
    logic [7:0]  led_m, led_s, led_d;
    logic [5:0]  low;
    logic        stable, any_low, one_low, settle_hit;
    logic [7:0]  cnt;
    logic        cnt_clr, cnt_inc, capture, multi;
    logic [3:0]  code;
    logic        bad;
    logic [2:0]  idx;
    logic [5:0]  mask, mask_next;
    logic [23:0] shadow;
    logic        pending;
    logic [31:0] tcount;

    // sel1 is the most significant digit, so it maps to bit 5 / nibble [23:20]
    assign sel_raw    = {sel1, sel2, sel3, sel4, sel5, sel6};
    assign low        = ~sel_s;
    assign stable     = (sel_s == sel_d) && (led_s == led_d);
    assign any_low    = |low;
    assign one_low    = any_low && ((low & (low - 6'd1)) == 6'd0);
    assign settle_hit = (cnt == 8'(SETTLE - 1));
    assign mask_next  = mask | (6'b000001 << idx);

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sel_m <= '1;
            sel_s <= '1;
            sel_d <= '1;
            led_m <= '1;
            led_s <= '1;
            led_d <= '1;
        end else begin
            sel_m <= sel_raw;
            sel_s <= sel_m;
            sel_d <= sel_s;
            led_m <= led;
            led_s <= led_m;
            led_d <= led_s;
        end
    end

    always_comb begin
        code = 4'hF;
        bad  = 1'b0;
        case (led_s)
            8'hC0: code = 4'h0;
            8'hF9: code = 4'h1;
            8'hA4: code = 4'h2;
            8'hB0: code = 4'h3;
            8'h99: code = 4'h4;
            8'h92: code = 4'h5;
            8'h82: code = 4'h6;
            8'hF8: code = 4'h7;
            8'h80: code = 4'h8;
            8'h90: code = 4'h9;
            8'hFF: code = 4'hA;
            8'h86: code = 4'hB;
            8'hAB: code = 4'hC;
            8'hA1: code = 4'hD;
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (low[i]) idx = 3'(i);
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Any low select enters SETTLE so that a multi-select fault can be timed and flagged
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        capture    = 1'b0;
        multi      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_low) begin
                    state_next = ST_SETTLE;
                    cnt_clr    = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!any_low) begin
                    state_next = ST_IDLE;
                    cnt_clr    = 1'b1;
                end else if (!stable) begin
                    cnt_clr = 1'b1;
                end else if (settle_hit) begin
                    state_next = ST_HOLD;
                    cnt_clr    = 1'b1;
                    capture    = one_low;
                    multi      = !one_low;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!stable) begin
                    cnt_clr    = 1'b1;
                    state_next = any_low ? ST_SETTLE : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n)       cnt <= 8'd0;
        else if (cnt_clr) cnt <= 8'd0;
        else if (cnt_inc) cnt <= cnt + 8'd1;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            mask        <= '0;
            pending     <= 1'b0;
            tcount      <= '0;
            data        <= '0;
            frame_stb   <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            pending   <= 1'b0;
            if (pending) begin
                data        <= shadow;
                frame_stb   <= 1'b1;
                frame_valid <= 1'b1;
                mask        <= '0;
            end
            if (capture) begin
                shadow[{idx, 2'b00} +: 4] <= code;
                mask    <= mask_next;
                pending <= (mask_next == 6'h3F);
                tcount  <= '0;
            end else begin
                if (tcount != '1) tcount <= tcount + 32'd1;
                // Link lost: drop the partial frame but keep the last good data
                if (tcount == 32'(TIMEOUT - 1)) begin
                    frame_valid <= 1'b0;
                    mask        <= '0;
                end
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            code_err <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            if (capture && bad) code_err <= 1'b1;
            else if (clr_err)   code_err <= 1'b0;
            if (multi)          sel_err  <= 1'b1;
            else if (clr_err)   sel_err  <= 1'b0;
        end
    end

endmodule

`default_nettype wire
